// File: rtl/hex_tx_pkg.sv
// hex_tx_pkg
// Shared definitions for the ASCII hex line printer on the UART debug path:
// ASCII constants, terminator encodings, the line FSM state type and the
// helper functions used to size the digit datapath and map nibbles to ASCII.
// No ports (package).

package hex_tx_pkg;

    localparam logic [7:0] ASCII_CR         = 8'h0D;
    localparam logic [7:0] ASCII_LF         = 8'h0A;
    localparam logic [7:0] ASCII_SP         = 8'h20;
    localparam logic [7:0] ASCII_DIGIT_BASE = 8'h30;
    // 0x37 + 10 = 0x41 ('A'), so letters reuse the same add-the-nibble form.
    localparam logic [7:0] ASCII_ALPHA_BASE = 8'h37;

    localparam int TERM_CRLF = 0;
    localparam int TERM_LF   = 1;
    localparam int TERM_SP   = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEX    = 2'd1,
        TERM_A = 2'd2,
        TERM_B = 2'd3
    } tx_state_t;

    function automatic int nib_count(input int width);
        return (width + 3) / 4;
    endfunction

    function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
        if (nibble < 4'd10)
            return ASCII_DIGIT_BASE + {4'h0, nibble};
        else
            return ASCII_ALPHA_BASE + {4'h0, nibble};
    endfunction

endpackage

// File: rtl/hex_tx_fifo.sv
// hex_tx_fifo
// Synchronous WIDTH x DEPTH word FIFO feeding the hex line printer.
// Ports:
//   clock    - system clock
//   reset_n  - synchronous active-low reset (empties the FIFO)
//   push     - write wr_data this edge (ignored when full)
//   wr_data  - word to store
//   pop      - drop the head this edge (ignored when empty)
//   rd_data  - current head word
//   count    - words stored
//   full     - count == DEPTH
//   empty    - count == 0

module hex_tx_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two; a simultaneous
    // push and pop leaves the count unchanged.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clock) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/hex_word_tx.sv
// hex_word_tx
// Queues WIDTH-bit words and prints each one as upper-case hex, MSB first,
// followed by a terminator, through the rs232out byte interface.
// Optional feature macro: HEX_TX_ZERO_SUPPRESS_EN (skip leading zero digits,
// always printing at least the last digit).
// Ports:
//   clock      - system clock
//   reset_n    - synchronous active-low reset
//   in_valid   - word offered
//   in_data    - word to print
//   in_ready   - FIFO can accept (count < DEPTH)
//   out_data   - ASCII byte to rs232out.transmit_data
//   out_we     - byte valid, to rs232out.we
//   out_busy   - rs232out.busy
//   fifo_count - words queued, excluding the line in progress
//   idle       - FIFO empty and FSM in IDLE

module hex_word_tx
    import hex_tx_pkg::*;
#(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4,
    parameter int TERM  = 0
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    output logic [7:0]             out_data,
    output logic                   out_we,
    input  logic                   out_busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   idle
);

    localparam int NIB  = nib_count(WIDTH);
    localparam int SR_W = NIB * 4;
    localparam int DC_W = $clog2(NIB + 1);
    localparam logic [DC_W-1:0] DC_LAST = DC_W'(1);
    localparam logic [7:0] TERM_BYTE = (TERM == TERM_CRLF) ? ASCII_CR :
                                       (TERM == TERM_LF)   ? ASCII_LF : ASCII_SP;

    tx_state_t        state, state_next;
    logic [SR_W-1:0]  sr, sr_next;
    logic [DC_W-1:0]  dc, dc_next;
    logic [WIDTH-1:0] fifo_rd_data;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic             consume;
    logic             skip;
    logic [3:0]       top_nib;

    hex_tx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (in_valid),
        .wr_data (in_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign in_ready = !fifo_full;
    assign idle     = (state == IDLE) && fifo_empty;
    assign consume  = out_we && !out_busy;
    assign top_nib  = sr[SR_W-1 -: 4];

`ifdef HEX_TX_ZERO_SUPPRESS_EN
    // 'leading' stays set from the pop until the first digit that will be
    // printed, so zeros after the first significant digit are never skipped.
    logic leading, leading_next;

    assign skip = leading && (top_nib == 4'h0) && (dc != DC_LAST);

    always_ff @(posedge clock) begin
        if (!reset_n)
            leading <= 1'b0;
        else
            leading <= leading_next;
    end

    always_comb begin
        leading_next = leading;
        if (state == IDLE && !fifo_empty)
            leading_next = 1'b1;
        else if (state == HEX && !skip)
            leading_next = 1'b0;
    end
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
            sr    <= '0;
            dc    <= '0;
        end else begin
            state <= state_next;
            sr    <= sr_next;
            dc    <= dc_next;
        end
    end

    // Outputs are decoded from the registered state, so out_data/out_we hold
    // steady for as long as rs232out stays busy.
    always_comb begin
        state_next = state;
        sr_next    = sr;
        dc_next    = dc;
        fifo_pop   = 1'b0;
        out_we     = 1'b0;
        out_data   = 8'h00;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    sr_next    = SR_W'(fifo_rd_data);
                    dc_next    = DC_W'(NIB);
                    state_next = HEX;
                end
            end
            HEX: begin
                if (skip) begin
                    sr_next = sr << 4;
                    dc_next = dc - 1'b1;
                end else begin
                    out_we   = 1'b1;
                    out_data = hex_ascii(top_nib);
                    if (consume) begin
                        sr_next = sr << 4;
                        dc_next = dc - 1'b1;
                        if (dc == DC_LAST)
                            state_next = TERM_A;
                    end
                end
            end
            TERM_A: begin
                out_we   = 1'b1;
                out_data = TERM_BYTE;
                if (consume)
                    state_next = (TERM == TERM_CRLF) ? TERM_B : IDLE;
            end
            TERM_B: begin
                out_we   = 1'b1;
                out_data = ASCII_LF;
                if (consume)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_hex_word_tx.sv
// tb_hex_word_tx
// Self-checking bench for hex_word_tx. dut_a: WIDTH=36, DEPTH=4, CR LF.
// dut_b: WIDTH=8, DEPTH=4, space terminator. Expected bytes come from a
// string-level formatter of each accepted word.

`timescale 1ns/1ps

module tb_hex_word_tx;

    localparam int A_NIB = 9;
`ifdef HEX_TX_ZERO_SUPPRESS_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;

    logic        a_valid = 1'b0;
    logic [35:0] a_data  = '0;
    logic        a_ready;
    logic [7:0]  a_out;
    logic        a_we;
    logic        a_busy  = 1'b0;
    logic [2:0]  a_count;
    logic        a_idle;

    logic        b_valid = 1'b0;
    logic [7:0]  b_data  = '0;
    logic        b_ready;
    logic [7:0]  b_out;
    logic        b_we;
    logic        b_busy  = 1'b0;
    logic [2:0]  b_count;
    logic        b_idle;

    int checks = 0;
    int errors = 0;
    int bytes_seen = 0;
    int words_accepted = 0;

    logic [7:0] exp_q[$];
    logic [7:0] line_buf[$];
    logic [7:0] b_got[$];
    logic       prev_hold = 1'b0;
    logic [7:0] prev_byte = 8'h00;

    always #5 clock = ~clock;

    hex_word_tx #(.WIDTH(36), .DEPTH(4), .TERM(0)) dut_a (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (a_valid),
        .in_data    (a_data),
        .in_ready   (a_ready),
        .out_data   (a_out),
        .out_we     (a_we),
        .out_busy   (a_busy),
        .fifo_count (a_count),
        .idle       (a_idle)
    );

    hex_word_tx #(.WIDTH(8), .DEPTH(4), .TERM(2)) dut_b (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (b_valid),
        .in_data    (b_data),
        .in_ready   (b_ready),
        .out_data   (b_out),
        .out_we     (b_we),
        .out_busy   (b_busy),
        .fifo_count (b_count),
        .idle       (b_idle)
    );

    task automatic checkOutput(input string tag, input logic [35:0] observed,
                               input logic [35:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Text a word should produce on dut_a: nine hex digits, optionally with
    // leading zeros stripped (keeping the last digit), then CR LF.
    function automatic void build_line(input logic [35:0] w);
        bit started = !ZS;
        line_buf.delete();
        for (int i = A_NIB - 1; i >= 0; i--) begin
            int d = int'((w >> (4 * i)) & 36'hF);
            if (d != 0 || i == 0)
                started = 1'b1;
            if (started)
                line_buf.push_back((d < 10) ? 8'(48 + d) : 8'(65 + d - 10));
        end
        line_buf.push_back(8'h0D);
        line_buf.push_back(8'h0A);
    endfunction

    // Monitor for dut_a: records accepted words into the expected byte
    // stream and checks every consumed byte and every held byte.
    always @(negedge clock) begin
        if (!reset_n) begin
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            checkOutput("ready_vs_count", a_ready, 36'(a_count < 3'd4));
            if (a_valid && a_ready) begin
                build_line(a_data);
                foreach (line_buf[i]) exp_q.push_back(line_buf[i]);
                words_accepted++;
            end
            if (prev_hold)
                checkOutput("hold_stable", {a_we, a_out}, {1'b1, prev_byte});
            if (a_we && !a_busy) begin
                checkOutput("byte_pending", 36'(exp_q.size() != 0), 36'd1);
                if (exp_q.size() != 0)
                    checkOutput("byte", a_out, exp_q.pop_front());
                bytes_seen++;
            end
            prev_hold = a_we && a_busy;
            prev_byte = a_out;
        end
    end

    always @(negedge clock) begin
        if (reset_n && b_we && !b_busy)
            b_got.push_back(b_out);
    end

    task automatic applyStimulus(input logic valid, input logic [35:0] data, input logic busy);
        @(posedge clock);
        #1;
        a_valid = valid;
        a_data  = data;
        a_busy  = busy;
    endtask

    task automatic pushWord(input logic [35:0] w);
        int n = 0;
        a_valid = 1'b1;
        a_data  = w;
        @(negedge clock);
        while (!a_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        checkOutput("push_accept", a_ready, 36'd1);
        @(posedge clock);
        #1;
        a_valid = 1'b0;
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        @(negedge clock);
        while (!(exp_q.size() == 0 && a_idle) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        checkOutput(tag, 36'(exp_q.size()), 36'd0);
        checkOutput({tag, "_idle"}, a_idle, 36'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic waitWe();
        int n = 0;
        @(negedge clock);
        while (!a_we && n < 200) begin
            @(negedge clock);
            n++;
        end
        checkOutput("wait_we", a_we, 36'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [35:0] w;
        logic [7:0]  b_exp [6];
        int base;
        int n;
        int len1;

        // Reset values
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("rst_we", a_we, 36'd0);
        checkOutput("rst_data", a_out, 36'h00);
        checkOutput("rst_count", a_count, 36'd0);
        checkOutput("rst_ready", a_ready, 36'd1);
        checkOutput("rst_idle", a_idle, 36'd1);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // First line and its latency: one IDLE cycle, then the first digit
        pushWord(36'h000000ABC);
        @(negedge clock);
        checkOutput("lat_count_t", a_count, 36'd1);
        checkOutput("lat_we_t", a_we, 36'd0);
        @(negedge clock);
        checkOutput("lat_count_t1", a_count, 36'd0);
        checkOutput("lat_we_t1", a_we, 36'(!ZS));
        checkOutput("lat_data_t1", a_out, ZS ? 36'h00 : 36'h30);
        @(posedge clock);
        #1;
        waitDrain("line_abc");

        pushWord(36'h0);
        waitDrain("line_zero");

        // Stall on the third digit for 40 cycles
        a_busy = 1'b1;
        pushWord(36'h000000ABC);
        for (int k = 0; k < 2; k++) begin
            waitWe();
            @(posedge clock);
            #1;
            a_busy = 1'b0;
            @(posedge clock);
            #1;
            a_busy = 1'b1;
        end
        repeat (40) @(negedge clock);
        build_line(36'h000000ABC);
        checkOutput("stall_we", a_we, 36'd1);
        checkOutput("stall_data", a_out, line_buf[2]);
        @(posedge clock);
        #1;
        a_busy = 1'b0;
        waitDrain("stall_resume");

        // Back-pressure: six words with rs232out busy
        a_busy = 1'b1;
        base = words_accepted;
        w = 36'({$urandom(), $urandom()});
        build_line(w);
        len1 = line_buf.size();
        pushWord(w);
        for (int k = 0; k < 4; k++)
            pushWord(36'({$urandom(), $urandom()}));
        a_valid = 1'b1;
        a_data  = 36'({$urandom(), $urandom()});
        repeat (8) @(negedge clock);
        checkOutput("full_count", a_count, 36'd4);
        checkOutput("full_ready", a_ready, 36'd0);
        checkOutput("full_idle", a_idle, 36'd0);
        checkOutput("full_accepted", 36'(words_accepted - base), 36'd5);
        @(posedge clock);
        #1;
        a_busy = 1'b0;
        base = bytes_seen;
        n = 0;
        while (!a_ready && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        checkOutput("sixth_ready", a_ready, 36'd1);
        checkOutput("sixth_after_pop", 36'(bytes_seen - base), 36'(len1));
        checkOutput("sixth_count", a_count, 36'd3);
        @(posedge clock);
        #1;
        a_valid = 1'b0;
        waitDrain("full_drain");

        // Reset during the fifth digit, with a second word queued
        base = bytes_seen;
        pushWord(36'h123456789);
        pushWord(36'h0000000FF);
        n = 0;
        while (bytes_seen < base + 4 && n < 200) begin
            @(posedge clock);
            n++;
        end
        checkOutput("mid_reached", 36'(bytes_seen >= base + 4), 36'd1);
        #1;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        checkOutput("mid_we", a_we, 36'd0);
        checkOutput("mid_count", a_count, 36'd0);
        checkOutput("mid_idle", a_idle, 36'd1);
        @(posedge clock);
        #1;
        pushWord(36'h1);
        waitDrain("fresh_line");

        // Random traffic against the line formatter
        for (int k = 0; k < 400; k++) begin
            w = 36'({$urandom(), $urandom()}) >> (4 * $urandom_range(0, 9));
            applyStimulus($urandom_range(0, 1) == 1, w, $urandom_range(0, 3) == 0);
        end
        applyStimulus(1'b0, 36'h0, 1'b0);
        waitDrain("random_drain");

        // Narrow instance with a space terminator
        b_exp = '{8'h35, 8'h46, 8'h20, 8'h41, 8'h30, 8'h20};
        b_valid = 1'b1;
        b_data  = 8'h5F;
        @(posedge clock);
        #1;
        b_data  = 8'hA0;
        @(posedge clock);
        #1;
        b_valid = 1'b0;
        n = 0;
        while (!(b_got.size() >= 6 && b_idle) && n < 200) begin
            @(negedge clock);
            n++;
        end
        checkOutput("b_len", 36'(b_got.size()), 36'd6);
        for (int i = 0; i < 6; i++)
            checkOutput($sformatf("b_byte%0d", i),
                        (i < b_got.size()) ? 36'(b_got[i]) : 36'hFFF, 36'(b_exp[i]));
        checkOutput("b_idle", b_idle, 36'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
